// File: rtl/dt_skeleton_if.sv
// Bus bundle for dt_skeleton: control handshake, SRAM port and scan results.
// The master side is the skeleton engine; the slave side is the SRAM/host environment.
interface dt_skeleton_if;
   logic        start;
   logic        abort;
   logic [19:0] SRAM_ADDR;
   logic        SRAM_CE;
   logic        SRAM_RW;
   logic        SRAM_HI;
   logic [7:0]  DQ_read;
   logic [7:0]  DQ_write;
   logic        busy;
   logic        done;
   logic [19:0] skel_count;
   logic [7:0]  max_val;
   logic [9:0]  max_x;
   logic [9:0]  max_y;

   modport master (
      input  start, abort, DQ_read,
      output SRAM_ADDR, SRAM_CE, SRAM_RW, SRAM_HI, DQ_write,
      output busy, done, skel_count, max_val, max_x, max_y
   );

   modport slave (
      output start, abort, DQ_read,
      input  SRAM_ADDR, SRAM_CE, SRAM_RW, SRAM_HI, DQ_write,
      input  busy, done, skel_count, max_val, max_x, max_y
   );
endinterface

// File: rtl/dt_skeleton.sv
// Distance-transform ridge extractor: reads a distance map from the SRAM lower byte and
// writes a local-maximum (skeleton) mask to the upper byte, tracking count and global max.
module dt_skeleton #(
   parameter int unsigned X_LAST   = 639,
   parameter int unsigned Y_LAST   = 479,
   parameter logic [7:0]  SKEL_VAL = 8'd255
) (
   input logic           clk,
   input logic           rst,
   dt_skeleton_if.master bus
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_WRITE, S_DONE} state_e;

   localparam logic [9:0] X_END = 10'(X_LAST - 1);
   localparam logic [9:0] Y_END = 10'(Y_LAST - 1);

   state_e      state_q, state_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [2:0]  nb_q, nb_d;
   logic [7:0]  c_q, c_d, nmax_q, nmax_d;
   logic        ridge_q, ridge_d;
   logic [19:0] addr_q, addr_d;
   logic        ce_q, ce_d, rw_q, rw_d, hi_q, hi_d;
   logic [7:0]  dq_q, dq_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [19:0] skel_q, skel_d;
   logic [7:0]  max_val_q, max_val_d;
   logic [9:0]  max_x_q, max_x_d, max_y_q, max_y_d;

   logic [7:0]  nmax_new;
   logic        ridge_new;
   logic        last_px;

   // Neighbour order: 0=centre, 1=left, 2=right, 3=up, 4=down.
   function automatic logic [19:0] nb_addr(input logic [9:0] x, input logic [9:0] y,
                                           input logic [2:0] nb);
      logic [19:0] a;
      case (nb)
         3'd1:    a = {y, x - 10'd1};
         3'd2:    a = {y, x + 10'd1};
         3'd3:    a = {y - 10'd1, x};
         3'd4:    a = {y + 10'd1, x};
         default: a = {y, x};
      endcase
      return a;
   endfunction

   assign nmax_new  = (nb_q == 3'd1) ? bus.DQ_read
                    : ((bus.DQ_read > nmax_q) ? bus.DQ_read : nmax_q);
   assign ridge_new = (c_q != 8'd0) && (c_q >= nmax_new);
   assign last_px   = (x_q == X_END) && (y_q == Y_END);

   // Next state; SRAM/status outputs are decoded from the next state so they come out registered.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      nb_d      = nb_q;
      c_d       = c_q;
      nmax_d    = nmax_q;
      ridge_d   = ridge_q;
      addr_d    = addr_q;
      ce_d      = 1'b1;
      rw_d      = 1'b1;
      hi_d      = 1'b0;
      dq_d      = 8'd0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      skel_d    = skel_q;
      max_val_d = max_val_q;
      max_x_d   = max_x_q;
      max_y_d   = max_y_q;

      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d   = S_ADDR;
                  x_d       = 10'd1;
                  y_d       = 10'd1;
                  nb_d      = 3'd0;
                  skel_d    = 20'd0;
                  max_val_d = 8'd0;
                  max_x_d   = 10'd0;
                  max_y_d   = 10'd0;
                  addr_d    = {10'd1, 10'd1};
                  ce_d      = 1'b0;
                  busy_d    = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ADDR: begin
               state_d = S_READ;
               ce_d    = 1'b0;
               busy_d  = 1'b1;
            end
            S_READ: begin
               busy_d = 1'b1;
               ce_d   = 1'b0;
               if (nb_q == 3'd0) begin
                  c_d = bus.DQ_read;
                  if (bus.DQ_read == 8'd0) begin
                     state_d = S_WRITE;
                     ridge_d = 1'b0;
                     addr_d  = {y_q, x_q};
                     rw_d    = 1'b0;
                     hi_d    = 1'b1;
                  end else begin
                     state_d = S_ADDR;
                     nb_d    = 3'd1;
                     addr_d  = nb_addr(x_q, y_q, 3'd1);
                  end
               end else begin
                  nmax_d = nmax_new;
                  if (nb_q == 3'd4) begin
                     state_d = S_WRITE;
                     ridge_d = ridge_new;
                     dq_d    = ridge_new ? SKEL_VAL : 8'd0;
                     addr_d  = {y_q, x_q};
                     rw_d    = 1'b0;
                     hi_d    = 1'b1;
                  end else begin
                     state_d = S_ADDR;
                     nb_d    = nb_q + 3'd1;
                     addr_d  = nb_addr(x_q, y_q, nb_q + 3'd1);
                  end
               end
            end
            S_WRITE: begin
               if (ridge_q) begin
                  skel_d = skel_q + 20'd1;
               end else begin
                  skel_d = skel_q;
               end
               // Strict compare keeps the earliest pixel in raster order on ties.
               if (c_q > max_val_q) begin
                  max_val_d = c_q;
                  max_x_d   = x_q;
                  max_y_d   = y_q;
               end else begin
                  max_val_d = max_val_q;
               end
               if (last_px) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  if (x_q == X_END) begin
                     x_d = 10'd1;
                     y_d = y_q + 10'd1;
                  end else begin
                     x_d = x_q + 10'd1;
                  end
                  state_d = S_ADDR;
                  nb_d    = 3'd0;
                  addr_d  = {y_d, x_d};
                  ce_d    = 1'b0;
                  busy_d  = 1'b1;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         nb_q      <= 3'd0;
         c_q       <= 8'd0;
         nmax_q    <= 8'd0;
         ridge_q   <= 1'b0;
         addr_q    <= 20'd0;
         ce_q      <= 1'b1;
         rw_q      <= 1'b1;
         hi_q      <= 1'b0;
         dq_q      <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         skel_q    <= 20'd0;
         max_val_q <= 8'd0;
         max_x_q   <= 10'd0;
         max_y_q   <= 10'd0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         nb_q      <= nb_d;
         c_q       <= c_d;
         nmax_q    <= nmax_d;
         ridge_q   <= ridge_d;
         addr_q    <= addr_d;
         ce_q      <= ce_d;
         rw_q      <= rw_d;
         hi_q      <= hi_d;
         dq_q      <= dq_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         skel_q    <= skel_d;
         max_val_q <= max_val_d;
         max_x_q   <= max_x_d;
         max_y_q   <= max_y_d;
      end
   end

   assign bus.SRAM_ADDR  = addr_q;
   assign bus.SRAM_CE    = ce_q;
   assign bus.SRAM_RW    = rw_q;
   assign bus.SRAM_HI    = hi_q;
   assign bus.DQ_write   = dq_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.skel_count = skel_q;
   assign bus.max_val    = max_val_q;
   assign bus.max_x      = max_x_q;
   assign bus.max_y      = max_y_q;

endmodule

// File: tb/tb_dt_skeleton.sv
// Self-checking bench for dt_skeleton on a reduced 16x12 frame: SRAM model, reference
// skeleton model, table-driven scans, random scans and abort/reset corner sequences.
module tb_dt_skeleton;
   localparam int XL   = 15;
   localparam int YL   = 11;
   localparam int W    = XL + 1;
   localparam int H    = YL + 1;
   localparam int NPIX = (XL - 1) * (YL - 1);

   typedef struct {
      int kind;
      int cnt;
      int mval;
      int mx;
      int my;
      int cyc;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   dt_skeleton_if bus ();
   dt_skeleton #(.X_LAST(XL), .Y_LAST(YL), .SKEL_VAL(8'd255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] lo     [W*H];
   logic [7:0] up     [W*H];
   logic [7:0] exp_up [W*H];
   int n_tests = 0;
   int n_fail  = 0;
   int wr_count, bad_wr;
   int mon_x, mon_y, mon_i;
   int m_count, m_max, m_mx, m_my, m_cyc;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // SRAM model: registered-style read data for the lower byte, upper-byte write capture.
   always @(negedge clk) begin
      if (bus.SRAM_CE == 1'b0) begin
         mon_x = int'(bus.SRAM_ADDR[9:0]);
         mon_y = int'(bus.SRAM_ADDR[19:10]);
         if (mon_x > XL || mon_y > YL) begin
            bad_wr++;
         end else begin
            mon_i = mon_y * W + mon_x;
            if (bus.SRAM_RW) begin
               if (bus.SRAM_HI) bad_wr++;
               bus.DQ_read = lo[mon_i];
            end else begin
               wr_count++;
               if (!bus.SRAM_HI || mon_x == 0 || mon_x == XL || mon_y == 0 || mon_y == YL)
                  bad_wr++;
               else
                  up[mon_i] = bus.DQ_write;
            end
         end
      end
   end

   // Reference: a pixel is a ridge when nonzero and not below any 4-neighbour.
   task automatic model();
      m_count = 0; m_max = 0; m_mx = 0; m_my = 0; m_cyc = 0;
      for (int i = 0; i < W*H; i++) exp_up[i] = 8'hA5;
      for (int y = 1; y < YL; y++) begin
         for (int x = 1; x < XL; x++) begin
            int c;
            int nm;
            c  = lo[y*W+x];
            nm = lo[y*W+x-1];
            if (lo[y*W+x+1] > nm) nm = lo[y*W+x+1];
            if (lo[(y-1)*W+x] > nm) nm = lo[(y-1)*W+x];
            if (lo[(y+1)*W+x] > nm) nm = lo[(y+1)*W+x];
            if (c != 0 && c >= nm) begin
               exp_up[y*W+x] = 8'd255;
               m_count++;
            end else begin
               exp_up[y*W+x] = 8'd0;
            end
            if (c > m_max) begin
               m_max = c; m_mx = x; m_my = y;
            end
            m_cyc += (c == 0) ? 3 : 11;
         end
      end
   endtask

   task automatic fill(input int kind);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int v;
            case (kind)
               3:       v = (x * 20 > 255) ? 255 : x * 20;
               4:       v = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
               default: v = 0;
            endcase
            lo[y*W+x] = 8'(v);
         end
      end
      if (kind == 1) lo[4*W+5] = 8'd7;
      if (kind == 2) begin
         lo[3*W+3] = 8'd5; lo[3*W+4] = 8'd5;
         lo[3*W+2] = 8'd4; lo[3*W+5] = 8'd4;
         lo[2*W+3] = 8'd4; lo[2*W+4] = 8'd4;
         lo[4*W+3] = 8'd4; lo[4*W+4] = 8'd4;
      end
   endtask

   task automatic run_scan(input string nm, input bit use_tab, input vec_t v, input bit mid_start);
      int cyc;
      int mism;
      int held;
      for (int i = 0; i < W*H; i++) up[i] = 8'hA5;
      model();
      wr_count = 0;
      bad_wr   = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      check({nm, ".first_addr"}, bus.SRAM_ADDR, {10'd1, 10'd1});
      check({nm, ".first_ce"}, bus.SRAM_CE, 0);
      check({nm, ".busy"}, bus.busy, 1);
      check({nm, ".cleared"}, {bus.skel_count, bus.max_val, bus.max_x, bus.max_y}, 0);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20000) begin
         bus.start = (mid_start && cyc == 40) ? 1'b1 : 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      check({nm, ".done_seen"}, bus.done, 1);
      check({nm, ".busy_in_done"}, bus.busy, 0);
      check({nm, ".cycles"}, cyc, m_cyc);
      if (use_tab) begin
         check({nm, ".tab_cycles"}, cyc, v.cyc);
         check({nm, ".tab_count"}, bus.skel_count, v.cnt);
         check({nm, ".tab_max"}, bus.max_val, v.mval);
         check({nm, ".tab_max_xy"}, {bus.max_x, bus.max_y}, {10'(v.mx), 10'(v.my)});
      end
      check({nm, ".count"}, bus.skel_count, m_count);
      check({nm, ".max"}, bus.max_val, m_max);
      check({nm, ".max_xy"}, {bus.max_x, bus.max_y}, {10'(m_mx), 10'(m_my)});
      mism = 0;
      for (int i = 0; i < W*H; i++) if (up[i] !== exp_up[i]) mism++;
      check({nm, ".plane_mismatches"}, mism, 0);
      check({nm, ".writes"}, wr_count, NPIX);
      check({nm, ".bad_writes"}, bad_wr, 0);
      held = int'(bus.skel_count);
      @(negedge clk);
      check({nm, ".done_pulse"}, bus.done, 0);
      check({nm, ".idle_ce"}, bus.SRAM_CE, 1);
      check({nm, ".result_hold"}, bus.skel_count, held);
   endtask

   vec_t tab[4];
   vec_t none;

   initial begin
      int cyc;
      int flag;
      int held;
      tab[0] = '{0, 0, 0, 0, 0, 420};
      tab[1] = '{1, 1, 7, 5, 4, 428};
      tab[2] = '{2, 2, 5, 3, 3, 484};
      tab[3] = '{3, 20, 255, 13, 1, 1540};
      none   = '{0, 0, 0, 0, 0, 0};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.ctrl", {bus.SRAM_CE, bus.SRAM_RW, bus.SRAM_HI}, 3'b110);
      check("reset.addr_dq", {bus.SRAM_ADDR, bus.DQ_write}, 0);
      check("reset.status", {bus.busy, bus.done}, 0);
      check("reset.results", {bus.skel_count, bus.max_val, bus.max_x, bus.max_y}, 0);
      rst = 1'b0;
      @(negedge clk);

      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      check("abort_start_idle.busy", bus.busy, 0);
      check("abort_start_idle.ce", bus.SRAM_CE, 1);

      for (int t = 0; t < 4; t++) begin
         fill(tab[t].kind);
         run_scan($sformatf("tab%0d", t), 1'b1, tab[t], 1'b0);
      end

      for (int r = 0; r < 3; r++) begin
         fill(4);
         run_scan($sformatf("rand%0d", r), 1'b0, none, r == 1);
      end

      fill(4);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (100) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort.ce", bus.SRAM_CE, 1);
      check("abort.busy", bus.busy, 0);
      check("abort.done", bus.done, 0);
      held = int'(bus.skel_count);
      flag = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.SRAM_CE !== 1'b1 || int'(bus.skel_count) != held) flag++;
      end
      check("abort.quiet_hold", flag, 0);
      fill(4);
      run_scan("after_abort", 1'b0, none, 1'b0);

      fill(4);
      lo[1*W+1] = 8'd3;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      cyc = 0;
      while (!(bus.SRAM_CE == 1'b0 && bus.SRAM_RW == 1'b0) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("rst.write_found", (cyc < 200), 1);
      #2 rst = 1'b1;
      #1;
      check("rst.ctrl", {bus.SRAM_CE, bus.SRAM_RW, bus.SRAM_HI}, 3'b110);
      check("rst.addr_dq", {bus.SRAM_ADDR, bus.DQ_write}, 0);
      check("rst.status", {bus.busy, bus.done}, 0);
      check("rst.results", {bus.skel_count, bus.max_val}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      flag = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.SRAM_CE !== 1'b1 || bus.busy !== 1'b0) flag++;
      end
      check("rst.no_access", flag, 0);
      fill(4);
      run_scan("after_rst", 1'b0, none, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
